// File: rtl/gpio_pad_bank.sv
// GPIO pad bank: per-channel tristate/open-drain pad drivers, 2-flop input
// synchronisers, counter-based debounce and latched edge interrupts.
module gpio_pad_bank #(
  parameter int N_CH = 8,
  parameter int DB_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [N_CH-1:0]   pad,
  input  logic [N_CH-1:0]   A,
  input  logic [N_CH-1:0]   OE,
  input  logic [N_CH-1:0]   IE,
  input  logic [N_CH-1:0]   OD,
  input  logic [DB_W-1:0]   db_limit,
  input  logic [N_CH-1:0]   rise_en,
  input  logic [N_CH-1:0]   fall_en,
  input  logic [N_CH-1:0]   irq_clr,
  output logic [N_CH-1:0]   Y,
  output logic [N_CH-1:0]   irq_status,
  output logic              irq
);

  localparam logic [DB_W-1:0] CNT_MAX = {DB_W{1'b1}};
  localparam logic [DB_W-1:0] CNT_ONE = DB_W'(1);

  logic [N_CH-1:0]            pad_en_s;
  logic [N_CH-1:0]            raw_s;
  logic [N_CH-1:0]            rise_s;
  logic [N_CH-1:0]            fall_s;
  logic [N_CH-1:0]            sync1_d, sync1_q;
  logic [N_CH-1:0]            sync2_d, sync2_q;
  logic [N_CH-1:0]            y_d, y_q;
  logic [N_CH-1:0]            irq_status_d, irq_status_q;
  logic [N_CH-1:0][DB_W-1:0]  cnt_d, cnt_q;

  // Open-drain only ever drives the low level, so an enabled pad always carries A.
  assign pad_en_s = rst_n ? (OE & ~(OD & A)) : {N_CH{1'b0}};

  for (genvar i = 0; i < N_CH; i++) begin : g_pad
    assign pad[i] = pad_en_s[i] ? A[i] : 1'bz;
  end

  assign raw_s = IE & pad;

  // Next-state: synchronisers, debounce counters, filtered data and interrupt latches
  always_comb begin
    sync1_d = raw_s;
    sync2_d = sync1_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (sync2_q[i] == y_q[i]) begin
        cnt_d[i] = {DB_W{1'b0}};
      end else if (cnt_q[i] >= db_limit) begin
        y_d[i]   = sync2_q[i];
        cnt_d[i] = {DB_W{1'b0}};
      end else if (cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    rise_s = ~y_q & y_d;
    fall_s = y_q & ~y_d;
    // A new event in the same cycle as a clear must not be lost.
    irq_status_d = ((rise_s & rise_en) | (fall_s & fall_en)) | (irq_status_q & ~irq_clr);
  end

  // State registers, cleared asynchronously so reset abandons any debounce in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= {N_CH{1'b0}};
      sync2_q      <= {N_CH{1'b0}};
      y_q          <= {N_CH{1'b0}};
      cnt_q        <= {(N_CH*DB_W){1'b0}};
      irq_status_q <= {N_CH{1'b0}};
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      irq_status_q <= irq_status_d;
    end
  end

  assign Y          = y_q;
  assign irq_status = irq_status_q;
  assign irq        = |irq_status_q;

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Directed self-checking bench for gpio_pad_bank with pull-ups on every pad.
module tb_gpio_pad_bank;

  localparam int N_CH = 8;
  localparam int DB_W = 4;

  logic            clk;
  logic            rst_n;
  wire  [N_CH-1:0] pad;
  logic [N_CH-1:0] A, OE, IE, OD, rise_en, fall_en, irq_clr;
  logic [DB_W-1:0] db_limit;
  logic [N_CH-1:0] Y, irq_status;
  logic            irq;
  logic [N_CH-1:0] ext_en, ext_val;

  int n_checks;
  int n_fail;

  gpio_pad_bank #(.N_CH(N_CH), .DB_W(DB_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pad        (pad),
    .A          (A),
    .OE         (OE),
    .IE         (IE),
    .OD         (OD),
    .db_limit   (db_limit),
    .rise_en    (rise_en),
    .fall_en    (fall_en),
    .irq_clr    (irq_clr),
    .Y          (Y),
    .irq_status (irq_status),
    .irq        (irq)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ext
    assign pad[i] = ext_en[i] ? ext_val[i] : 1'bz;
    pullup pu (pad[i]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    A        = 8'h00;
    OE       = 8'hFF;
    IE       = 8'h00;
    OD       = 8'h00;
    rise_en  = 8'h00;
    fall_en  = 8'h00;
    irq_clr  = 8'h00;
    db_limit = 4'd0;
    ext_en   = 8'h00;
    ext_val  = 8'h00;
    #3;
    // Reset state: pads released (pull-ups read 1) even with OE all set
    check("rst_pad", pad, 8'hFF);
    check("rst_y", Y, 8'h00);
    check("rst_irq_status", irq_status, 8'h00);
    check("rst_irq", irq, 1'b0);
    OE = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Channel 0: db_limit=0, external rising edge appears two edges after sampling
    IE[0] = 1'b1; ext_en[0] = 1'b1; ext_val[0] = 1'b0;
    tick(3);
    ext_val[0] = 1'b1;
    tick(1);
    check("ch0_edge_k", Y[0], 1'b0);
    tick(1);
    check("ch0_edge_k1", Y[0], 1'b0);
    tick(1);
    check("ch0_edge_k2", Y[0], 1'b1);

    // Channel 1: db_limit=3, 3-cycle glitch rejected, 4-cycle pulse accepted
    db_limit = 4'd3;
    IE[1] = 1'b1; ext_en[1] = 1'b1; ext_val[1] = 1'b0;
    tick(3);
    ext_val[1] = 1'b1;
    tick(3);
    ext_val[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("ch1_glitch", Y[1], 1'b0);
    end
    ext_val[1] = 1'b1;
    tick(4);
    ext_val[1] = 1'b0;
    tick(1);
    check("ch1_pulse_k4", Y[1], 1'b0);
    tick(1);
    check("ch1_pulse_k5", Y[1], 1'b1);
    tick(10);
    check("ch1_back_low", Y, 8'h01);

    // Channel 2: open-drain and push-pull output levels
    OE[2] = 1'b1; OD[2] = 1'b1; A[2] = 1'b0;
    #1 check("ch2_od_low", pad[2], 1'b0);
    A[2] = 1'b1;
    #1 check("ch2_od_release", pad[2], 1'b1);
    OD[2] = 1'b0; A[2] = 1'b0;
    #1 check("ch2_pp_low", pad[2], 1'b0);
    A[2] = 1'b1;
    #1 check("ch2_pp_high", pad[2], 1'b1);
    OE[2] = 1'b0; A[2] = 1'b0;
    tick(1);

    // Channel 3: rising interrupt, clear collides with a new event, then lone clear
    db_limit = 4'd0;
    rise_en[3] = 1'b1; IE[3] = 1'b1; ext_en[3] = 1'b1; ext_val[3] = 1'b0;
    tick(3);
    ext_val[3] = 1'b1;
    tick(2);
    check("ch3_irq_before", irq_status[3], 1'b0);
    tick(1);
    check("ch3_irq_set", irq_status[3], 1'b1);
    check("ch3_irq_out", irq, 1'b1);
    ext_val[3] = 1'b0;
    tick(4);
    check("ch3_latched", irq_status[3], 1'b1);
    ext_val[3] = 1'b1;
    tick(2);
    irq_clr[3] = 1'b1;
    tick(1);
    irq_clr[3] = 1'b0;
    check("ch3_set_wins", irq_status[3], 1'b1);
    check("ch3_set_wins_y", Y[3], 1'b1);
    irq_clr[3] = 1'b1;
    tick(1);
    irq_clr[3] = 1'b0;
    check("ch3_cleared", irq_status[3], 1'b0);
    check("ch3_irq_low", irq, 1'b0);

    // Channel 4: dropping IE acts as a falling input
    fall_en[4] = 1'b1; IE[4] = 1'b1; ext_en[4] = 1'b1; ext_val[4] = 1'b1;
    tick(4);
    check("ch4_high", Y[4], 1'b1);
    check("ch4_no_irq", irq_status[4], 1'b0);
    IE[4] = 1'b0;
    tick(3);
    check("ch4_ie_fall", Y[4], 1'b0);
    check("ch4_fall_irq", irq_status[4], 1'b1);
    check("ch4_irq_out", irq, 1'b1);

    // Asynchronous reset mid-count with all outputs enabled
    ext_en = 8'h00;
    db_limit = 4'd3;
    A  = 8'hAA;
    OE = 8'hFF;
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pad", pad, 8'hFF);
    check("arst_y", Y, 8'h00);
    check("arst_irq_status", irq_status, 8'h00);
    check("arst_irq", irq, 1'b0);
    OE = 8'h00;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_y", Y, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
